dense_row_pingpong_buffer: RTL and testbench

- Sits directly downstream of the dense-2 layer and upstream of the dense-3 layer.
- Captures the single-word ReLU outputs (wr_addr/wr_data/wr_en, 84 words) into one of two register banks.
- Zero-pads each bank to SEG_NUM*SEG_LEN words and serves 25-word segments to the next layer's 25-lane inner-product read port.
- Double-buffers so the producer can fill one bank while the consumer reads the other, and generates the consumer's level-sensitive enable.

---
 rtl/dense_row_pingpong_buffer_pkg.sv | 17 +
 rtl/dense_row_pingpong_buffer_rise_edge_det.sv | 22 ++
 rtl/dense_row_pingpong_buffer.sv | 110 +++++++++++
 tb/tb_dense_row_pingpong_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dense_row_pingpong_buffer_pkg.sv
// Shared constants and types for the dense-layer row buffers.
// Per-layer segment geometry and the bank index type live here.
package dense_row_pingpong_buffer_pkg;
  localparam int LAYER_DATA_W  = 16;
  localparam int LAYER_SEG_LEN = 25;

  localparam int DENSE2_SEG_NUM     = 5;
  localparam int DENSE2_VALID_WORDS = 120;
  localparam int DENSE3_SEG_NUM     = 4;
  localparam int DENSE3_VALID_WORDS = 84;

  typedef logic bank_idx_t;

  function automatic int bank_depth(input int seg_num, input int seg_len);
    return seg_num * seg_len;
  endfunction
endpackage

// File: rtl/dense_row_pingpong_buffer_rise_edge_det.sv
// Registered rising-edge detector for level-style work_finished strobes.
// rise is high for the single cycle where level is 1 and its registered history is 0.
module rise_edge_det
  import dense_row_pingpong_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level && !prev;
endmodule

// File: rtl/dense_row_pingpong_buffer.sv
// Two-bank ping-pong buffer between the dense-2 producer and the dense-3 consumer.
// The producer fills one bank word by word while the consumer reads 25-word segments from the other.
module dense_row_pingpong_buffer
  import dense_row_pingpong_buffer_pkg::*;
#(
  parameter int DATA_W      = LAYER_DATA_W,
  parameter int SEG_LEN     = LAYER_SEG_LEN,
  parameter int SEG_NUM     = DENSE3_SEG_NUM,
  parameter int VALID_WORDS = DENSE3_VALID_WORDS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_in,
  input  logic [31:0]               wr_addr_in,
  input  logic [DATA_W-1:0]         wr_data_in,
  input  logic                      wr_done_in,
  output logic                      prod_en_out,
  output logic                      cons_en_out,
  input  logic [31:0]               rd_addr_in,
  output logic [SEG_LEN*DATA_W-1:0] rd_data_out,
  input  logic                      cons_done_in,
  output logic                      overflow_out
);
  localparam int DEPTH = bank_depth(SEG_NUM, SEG_LEN);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0]         mem [2][DEPTH];
  logic [1:0]                bank_full;
  bank_idx_t                 wr_bank;
  bank_idx_t                 rd_bank;
  logic                      wr_rise;
  logic                      cons_rise;
  logic                      wr_ok;
  logic                      wr_bad;
  logic                      fill_close;
  logic                      close_bad;
  logic                      release_pending;
  logic [SEG_LEN*DATA_W-1:0] seg_word;

  rise_edge_det u_wr_done_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (wr_done_in),
    .rise  (wr_rise)
  );

  rise_edge_det u_cons_done_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (cons_done_in),
    .rise  (cons_rise)
  );

  // The write bank is only ever full when the other bank is full as well,
  // so a full write bank means no bank can accept data or a close.
  assign wr_ok           = wr_en_in && !bank_full[wr_bank] && (wr_addr_in < 32'(VALID_WORDS));
  assign wr_bad          = wr_en_in && !wr_ok;
  assign fill_close      = wr_rise && !bank_full[wr_bank];
  assign close_bad       = wr_rise && bank_full[wr_bank];
  assign release_pending = cons_rise && cons_en_out;

  always_comb begin
    seg_word = '0;
    if (rd_addr_in < 32'(SEG_NUM)) begin
      for (int i = 0; i < SEG_LEN; i++) begin
        seg_word[i*DATA_W +: DATA_W] =
          mem[rd_bank][IDX_W'(rd_addr_in * 32'(SEG_LEN) + 32'(i))];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[b][w] <= '0;
        end
      end
      bank_full    <= '0;
      wr_bank      <= '0;
      rd_bank      <= '0;
      prod_en_out  <= 1'b0;
      cons_en_out  <= 1'b0;
      rd_data_out  <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_bank][wr_addr_in[IDX_W-1:0]] <= wr_data_in;
      end
      // A released bank is zeroed so a partial refill reads back zero-padded.
      if (release_pending) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[rd_bank][w] <= '0;
        end
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
      if (fill_close) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= ~wr_bank;
      end
      prod_en_out <= !fill_close && !bank_full[wr_bank];
      cons_en_out <= bank_full[rd_bank] && !release_pending;
      rd_data_out <= seg_word;
      if (wr_bad || close_bad) begin
        overflow_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dense_row_pingpong_buffer.sv
// Self-checking bench: directed test-plan scenarios followed by a random phase,
// checked against a queue-of-banks reference model and a read-data scoreboard.
module tb_dense_row_pingpong_buffer;
  localparam int DW     = 16;
  localparam int SL     = 25;
  localparam int SN     = 4;
  localparam int VW     = 84;
  localparam int SEG_W  = SL * DW;
  localparam int BANK_W = SN * SL * DW;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              wr_en     = 1'b0;
  logic [31:0]       wr_addr   = '0;
  logic [DW-1:0]     wr_data   = '0;
  logic              wr_done   = 1'b0;
  logic [31:0]       rd_addr   = '0;
  logic              cons_done = 1'b0;
  logic              prod_en;
  logic              cons_en;
  logic              overflow;
  logic [SEG_W-1:0]  rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model: closed banks wait in order in full_q; fill_buf is the bank being filled.
  logic [BANK_W-1:0] full_q[$];
  logic [BANK_W-1:0] fill_buf = '0;
  logic              m_ovf    = 1'b0;

  logic [SEG_W-1:0]  exp_q[$];
  logic [SEG_W-1:0]  mon_exp;
  logic              rd_issue   = 1'b0;
  logic              rd_issue_d = 1'b0;

  always #5 clk = ~clk;

  dense_row_pingpong_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_in     (wr_en),
    .wr_addr_in   (wr_addr),
    .wr_data_in   (wr_data),
    .wr_done_in   (wr_done),
    .prod_en_out  (prod_en),
    .cons_en_out  (cons_en),
    .rd_addr_in   (rd_addr),
    .rd_data_out  (rd_data),
    .cons_done_in (cons_done),
    .overflow_out (overflow)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0b required %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_seg(input string name, input logic [SEG_W-1:0] act, input logic [SEG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [SEG_W-1:0] model_seg(input int addr);
    logic [BANK_W-1:0] src;
    src = (full_q.size() > 0) ? full_q[0] : fill_buf;
    if (addr < 0 || addr >= SN) return '0;
    return src[addr*SEG_W +: SEG_W];
  endfunction

  task automatic model_reset();
    full_q.delete();
    fill_buf = '0;
    m_ovf    = 1'b0;
  endtask

  // Read monitor: one-cycle latency, so a request issued this cycle is checked next negedge.
  always @(posedge clk) rd_issue_d <= rd_issue;

  always @(negedge clk) begin
    if (rd_issue_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data no expected entry at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check_seg("rd_data", rd_data, mon_exp);
      end
    end
  end

  task automatic do_write(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = 32'(addr);
    wr_data = data;
    if (addr < VW && full_q.size() < 2) fill_buf[addr*DW +: DW] = data;
    else m_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input int addr);
    rd_addr = 32'(addr);
    exp_q.push_back(model_seg(addr));
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic do_close();
    bit accept;
    accept  = (full_q.size() < 2);
    wr_done = 1'b1;
    if (accept) begin
      full_q.push_back(fill_buf);
      fill_buf = '0;
    end else begin
      m_ovf = 1'b1;
    end
    @(negedge clk);
    wr_done = 1'b0;
    if (accept) check_bit("prod_en_drop_on_close", prod_en, 1'b0);
    @(negedge clk);
    check_bit("prod_en_after_close", prod_en, full_q.size() < 2);
    check_bit("cons_en_after_close", cons_en, full_q.size() > 0);
    check_bit("overflow_after_close", overflow, m_ovf);
  endtask

  task automatic do_release();
    cons_done = 1'b1;
    if (full_q.size() > 0) void'(full_q.pop_front());
    @(negedge clk);
    cons_done = 1'b0;
    check_bit("cons_en_low_on_release", cons_en, 1'b0);
    @(negedge clk);
    check_bit("cons_en_after_release", cons_en, full_q.size() > 0);
    check_bit("prod_en_after_release", prod_en, full_q.size() < 2);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_bit("reset_prod_en", prod_en, 1'b0);
    check_bit("reset_cons_en", cons_en, 1'b0);
    check_bit("reset_overflow", overflow, 1'b0);
    check_seg("reset_rd_data", rd_data, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("prod_en_after_reset", prod_en, 1'b1);
    check_bit("cons_en_after_reset", cons_en, 1'b0);
  endtask

  initial begin
    int op;
    repeat (2) @(negedge clk);
    apply_reset();

    // Fill bank 0 with k+1, close, read segments including the padded tail.
    for (int k = 0; k < VW; k++) do_write(k, DW'(k + 1));
    do_close();
    do_read(0);
    do_read(3);
    do_read(4);

    // Fill bank 1 while bank 0 is held by the consumer, then hand it over.
    for (int k = 0; k < VW; k++) do_write(k, DW'(16'h0100 + k));
    do_close();
    do_release();
    do_read(0);

    // Both banks full: close and write are rejected.
    do_close();
    do_write(5, 16'h7FFF);
    check_bit("prod_en_both_full", prod_en, 1'b0);
    repeat (3) @(negedge clk);
    check_bit("overflow_sticky", overflow, 1'b1);

    // Released bank comes back zeroed; a single-word refill reads back padded.
    do_release();
    do_write(0, 16'h0005);
    do_close();
    do_release();
    do_read(0);
    do_read(1);
    check_bit("cons_en_before_reset", cons_en, 1'b1);

    // Asynchronous reset while the consumer is active.
    apply_reset();
    for (int a = 0; a < 5; a++) do_read(a);

    // Out-of-range addresses are dropped.
    do_write(84, 16'h1234);
    do_write(200, 16'h4321);
    check_bit("overflow_out_of_range", overflow, 1'b1);
    do_read(3);

    // Random phase from a clean state.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        if ($urandom_range(0, 15) == 0) do_write(int'($urandom_range(84, 300)), DW'($urandom));
        else do_write(int'($urandom_range(0, 83)), DW'($urandom));
      end else if (op <= 7) begin
        do_read(int'($urandom_range(0, 5)));
      end else if (op == 8) begin
        do_close();
      end else begin
        do_release();
      end
    end
    check_bit("overflow_end_random", overflow, m_ovf);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
